alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, registered successor of the 8-operation combinational ALU. Adds a persistent carry flag for chained multi-word ADC/SBB, NZV status flags, a valid/ready handshake on both sides and a multi-cycle serial multiply. It sits between the operand/control source and the result sink in the datapath, replacing the flat select mux with a single registered output stage.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 2).
- SEL_W, 4, opcode width; fixed to 4 for this generation.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  request accepted when in_valid && in_ready.
- a  in  WIDTH  operand A.
- w  in  WIDTH  operand W.
- cin  in  1  external carry-in for ADC/SBB.
- use_cflag  in  1  1: ADC/SBB take carry from internal C flag instead of cin.
- s  in  SEL_W  opcode.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  sink accepts result when out_valid && out_ready.
- d  out  WIDTH  result (MUL: low half).
- d_hi  out  WIDTH  MUL high half; 0 for all other ops.
- cout  out  1  carry/borrow of the result (copy of C flag).
- zero, neg, ovf  out  1 each  Z, N, V flags of the result.
- busy  out  1  multiply in progress.

## Operation
- Opcodes: 0 ADD a+w; 1 SUB a−w; 2 OR; 3 AND; 4 ADC a+w+c; 5 SBB a−w−c; 6 NOT ~a; 7 PASS a; 8 XOR; 9 SHL a<<1; 10 SHR a>>1 (logical); 11 MUL a×w unsigned, 2·WIDTH result; 12–15 reserved.
- c = use_cflag ? C : cin. Ignored by non-ADC/SBB ops.
- Arithmetic at WIDTH+1 bits. ADD/ADC: C = carry out. SUB/SBB: C = borrow (1 when a < w + c, unsigned). SHL: C = a[MSB]; SHR: C = a[0]. Logic ops, NOT, PASS, MUL: C = 0.
- V: signed overflow for ADD/ADC/SUB/SBB; 0 otherwise.
- Z = (d == 0) (MUL: whole 2·WIDTH product == 0). N = d[MSB] (MUL: d_hi[MSB]).
- Reserved opcodes: d = 0, d_hi = 0, C = 0, V = 0, Z = 1, N = 0; accepted normally, no error.
- Flag register (C, Z, N, V) and d/d_hi load together only when a result is written to the output register; they persist until the next result.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: in_ready = !out_valid || out_ready. Accept single-cycle op → result registered same edge, stay IDLE. Accept MUL → latch a, w, clear accumulator, MUL.
  - MUL: shift-add, one bit of w per cycle, WIDTH cycles; busy = 1, in_ready = 0. After last step → load d/d_hi/flags, out_valid = 1, IDLE if the output register is free that edge, else HOLD.
  - HOLD: product waits for out_valid to clear; loads on the edge out_ready is seen, then IDLE.
- out_valid sets on result load; clears on out_valid && out_ready with no simultaneous load; stays 1 with new data on simultaneous consume+load.

## Timing
- Reset (async assert, sync-released use): state IDLE, out_valid 0, d 0, d_hi 0, cout/zero/neg/ovf 0, busy 0, in_ready 1 (out_valid is 0).
- Single-cycle op accepted at edge T: d/flags valid with out_valid = 1 after edge T, i.e. latency 1.
- Back-to-back throughput 1 op/cycle while out_ready = 1.
- Chained ADC/SBB with use_cflag: op at edge T+1 sees C produced by op at edge T; no bubble.
- MUL accepted at edge T: out_valid after edge T+WIDTH; C flag read by a following op is the MUL result (0).
- out_ready low: output register, flags, in_ready = 0 held stable; no result lost or overwritten.
- rst_n asserted mid-MUL: multiply aborted, all outputs to reset values immediately.

## Structure
- Package alu_pipe_pkg: opcode localparams (OP_ADD … OP_MUL), state enum (IDLE, MUL, HOLD), flag index constants.
- Sub-module alu_mul_serial: WIDTH-cycle unsigned shift-add multiplier with start/done; combinational ops and flag logic stay in the top.

## Test plan
- Reset then ADD a=8'h7F w=8'h01 cin=0 → next cycle d=8'h80, cout=0, ovf=1, neg=1, zero=0.
- SUB a=8'h05 w=8'h06 → d=8'hFF, cout=1 (borrow), neg=1; then SBB use_cflag=1 a=8'h00 w=8'h00 → d=8'hFF, cout=1.
- 16-bit chain: ADD 8'hFF+8'h01 → d=00, cout=1, zero=1; ADC use_cflag=1 8'h00+8'h00 → d=01, cout=0.
- MUL a=8'hFF w=8'hFF → busy for 8 cycles, in_ready=0; out_valid at T+8 with d_hi=8'hFE, d=8'h01, zero=0.
- Backpressure: out_ready=0 with result held, issue ADD → in_ready=0, d unchanged; raise out_ready → new result next cycle, no loss.
- rst_n pulsed low during MUL cycle 4 → out_valid=0, busy=0, in_ready=1 after release; reserved opcode 13 then gives d=0, zero=1.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared opcodes, FSM states and flag-register layout for the registered ALU.
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_ADC = 4'd4;
  localparam logic [3:0] OP_SBB = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_PAS = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam int unsigned FLAG_C    = 0;
  localparam int unsigned FLAG_Z    = 1;
  localparam int unsigned FLAG_N    = 2;
  localparam int unsigned FLAG_V    = 3;
  localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_serial.sv
// WIDTH-cycle unsigned shift-add multiplier. After done the registers keep the
// final product, so it can be read later while the result waits for the sink.
module alu_mul_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   w,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_step, lo_step;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    hi_step = sum[WIDTH:1];
    lo_step = {sum[0], lo_q[WIDTH-1:1]};
    done    = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    // While running, expose the value the final step is about to store.
    product = run_q ? {hi_step, lo_step} : {hi_q, lo_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      mcand_q <= a;
      hi_q    <= '0;
      lo_q    <= w;
      cnt_q   <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with persistent C flag, NZV status, valid/ready on both sides
// and a serial multiply; all results pass through one output register.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] w,
  input  logic             cin,
  input  logic             use_cflag,
  input  logic [SEL_W-1:0] s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_hi,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned MSB = WIDTH - 1;

  state_e                 state_q, state_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       d_q, d_d, dhi_q, dhi_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;

  logic                   out_free, accept, load, mul_start, mul_done;
  logic [2*WIDTH-1:0]     mul_prod;
  logic                   carry;
  logic [WIDTH:0]         add_x, sub_x, c_x;
  logic [WIDTH-1:0]       alu_d;
  logic                   alu_c, alu_v;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == StIdle) && out_free;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == StMul);

  alu_mul_serial #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .w       (w),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    carry = use_cflag ? flags_q[FLAG_C] : cin;
    c_x   = {{WIDTH{1'b0}}, carry};
    add_x = {1'b0, a} + {1'b0, w} + ((s == OP_ADC) ? c_x : '0);
    // Bit WIDTH of the difference is the unsigned borrow.
    sub_x = {1'b0, a} - {1'b0, w} - ((s == OP_SBB) ? c_x : '0);
  end

  always_comb begin
    alu_d = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (s)
      OP_ADD, OP_ADC: begin
        alu_d = add_x[MSB:0];
        alu_c = add_x[WIDTH];
        alu_v = (a[MSB] == w[MSB]) && (add_x[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBB: begin
        alu_d = sub_x[MSB:0];
        alu_c = sub_x[WIDTH];
        alu_v = (a[MSB] != w[MSB]) && (sub_x[MSB] != a[MSB]);
      end
      OP_OR:  alu_d = a | w;
      OP_AND: alu_d = a & w;
      OP_NOT: alu_d = ~a;
      OP_PAS: alu_d = a;
      OP_XOR: alu_d = a ^ w;
      OP_SHL: begin
        alu_d = {a[MSB-1:0], 1'b0};
        alu_c = a[MSB];
      end
      OP_SHR: begin
        alu_d = {1'b0, a[MSB:1]};
        alu_c = a[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    mul_start = 1'b0;
    d_d       = d_q;
    dhi_d     = dhi_q;
    flags_d   = flags_q;
    unique case (state_q)
      StIdle: begin
        if (accept && (s == OP_MUL)) begin
          mul_start = 1'b1;
          state_d   = StMul;
        end else if (accept) begin
          load            = 1'b1;
          d_d             = alu_d;
          dhi_d           = '0;
          flags_d[FLAG_C] = alu_c;
          flags_d[FLAG_Z] = (alu_d == '0);
          flags_d[FLAG_N] = alu_d[MSB];
          flags_d[FLAG_V] = alu_v;
        end
      end
      StMul: begin
        if (mul_done) begin
          load    = out_free;
          state_d = out_free ? StIdle : StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          load    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load && (state_q != StIdle)) begin
      d_d             = mul_prod[WIDTH-1:0];
      dhi_d           = mul_prod[2*WIDTH-1:WIDTH];
      flags_d[FLAG_C] = 1'b0;
      flags_d[FLAG_Z] = (mul_prod == '0);
      flags_d[FLAG_N] = mul_prod[2*WIDTH-1];
      flags_d[FLAG_V] = 1'b0;
    end
    out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      dhi_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      dhi_q       <= dhi_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign d_hi      = dhi_q;
  assign cout      = flags_q[FLAG_C];
  assign zero      = flags_q[FLAG_Z];
  assign neg       = flags_q[FLAG_N];
  assign ovf       = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed vectors, multi-cycle corner sequences and a randomized scoreboard
// run for alu_pipe at WIDTH = 8.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] a = '0, w = '0;
  logic       cin = 1'b0, use_cflag = 1'b0;
  logic [3:0] s = '0;
  logic       out_valid, out_ready = 1'b1;
  logic [7:0] d, d_hi;
  logic       cout, zero, neg, ovf, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [7:0] dh;
    logic [7:0] d;
    logic       c, z, n, v;
  } res_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, w;
    logic       cin, ucf;
    logic [7:0] d;
    logic       c, z, n, v;
  } vec_t;

  alu_pipe #(.WIDTH(8), .SEL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .w         (w),
    .cin       (cin),
    .use_cflag (use_cflag),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .d_hi      (d_hi),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic res_t outs();
    return {d_hi, d, cout, zero, neg, ovf};
  endfunction

  // Reference computed with plain integer arithmetic on the opcode rules.
  function automatic res_t model(input logic [3:0] op, input logic [7:0] aa, ww,
                                 input logic c);
    res_t e;
    int ua, uw, sa, sw, ci, r, sr;
    e  = '0;
    ua = int'(aa);
    uw = int'(ww);
    sa = (ua >= 128) ? ua - 256 : ua;
    sw = (uw >= 128) ? uw - 256 : uw;
    ci = 0;
    case (op)
      4'd0, 4'd4: begin
        if (op == 4'd4) ci = int'(c);
        r = ua + uw + ci;
        sr = sa + sw + ci;
        e.d = r[7:0];
        e.c = (r > 255);
        e.v = (sr > 127) || (sr < -128);
      end
      4'd1, 4'd5: begin
        if (op == 4'd5) ci = int'(c);
        r = ua - uw - ci;
        sr = sa - sw - ci;
        e.d = r[7:0];
        e.c = (ua < uw + ci);
        e.v = (sr > 127) || (sr < -128);
      end
      4'd2: e.d = aa | ww;
      4'd3: e.d = aa & ww;
      4'd6: e.d = ~aa;
      4'd7: e.d = aa;
      4'd8: e.d = aa ^ ww;
      4'd9: begin
        r = (ua * 2) % 256;
        e.d = r[7:0];
        e.c = (ua >= 128);
      end
      4'd10: begin
        r = ua / 2;
        e.d = r[7:0];
        e.c = (ua % 2) == 1;
      end
      4'd11: begin
        r = ua * uw;
        e.d = r[7:0];
        e.dh = r[15:8];
        e.z = (r == 0);
        e.n = (r >= 32768);
        return e;
      end
      default: ;
    endcase
    e.z = (e.d == 8'h00);
    e.n = e.d[7];
    return e;
  endfunction

  // Present one request, wait (bounded) for acceptance, return 1 ns after that edge.
  task automatic do_op(input logic [3:0] op, input logic [7:0] aa, ww, input logic ci, uc);
    int n;
    @(negedge clk);
    s = op; a = aa; w = ww; cin = ci; use_cflag = uc; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  vec_t vecs[15];
  res_t q[$];
  logic model_c;

  initial begin
    vecs[0]  = '{4'd0,  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{4'd1,  8'h05, 8'h06, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{4'd5,  8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'd0,  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'd4,  8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd2,  8'hA0, 8'h05, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'd3,  8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd6,  8'h0F, 8'h00, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{4'd7,  8'h00, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'd8,  8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'd9,  8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd10, 8'h81, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'd4,  8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{4'd5,  8'h80, 8'h00, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{4'd14, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_ctl", {29'd0, out_valid, busy, in_ready}, 32'b001);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one op at a time with the sink always ready
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].w, vecs[i].cin, vecs[i].ucf);
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({8'h00, vecs[i].d, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v}));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
    end

    // MUL FF*FF: busy for 8 cycles, result after the 8th edge
    do_op(4'd11, 8'hFF, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul_busy%0d", i), {29'd0, busy, in_ready, out_valid}, 32'b100);
      @(posedge clk);
      #1;
    end
    chk("mul_result", 32'(outs()), 32'({8'hFE, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0}));
    chk("mul_done_ctl", {29'd0, busy, in_ready, out_valid}, 32'b011);
    // ADC chained after MUL sees C = 0
    do_op(4'd4, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("adc_after_mul", 32'(outs()), 32'({8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));

    // Backpressure: held result must not be overwritten
    do_op(4'd0, 8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    s = 4'd0; a = 8'h10; w = 8'h20; cin = 1'b0; use_cflag = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_hold%0d", i), {23'd0, out_valid, d}, {23'd0, 1'b1, 8'h03});
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_new_result", {23'd0, out_valid, d}, {23'd0, 1'b1, 8'h30});

    // Reset pulsed in the middle of a multiply
    do_op(4'd11, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mul_outs", 32'(outs()), 32'd0);
    chk("rst_mul_ctl", {30'd0, out_valid, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mul_ready", {30'd0, in_ready, busy}, 32'b10);
    do_op(4'd13, 8'hFF, 8'hFF, 1'b1, 1'b1);
    chk("reserved13", 32'(outs()), 32'({8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));

    // Flush the held result, then randomized traffic against the model
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("flush", 32'(out_valid), 32'd0);
    model_c = 1'b0;
    begin
      logic pend;
      pend = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(negedge clk);
        if (!pend && $urandom_range(0, 3) != 0) begin
          s = 4'($urandom_range(0, 15));
          a = 8'($urandom);
          w = 8'($urandom);
          cin = 1'($urandom);
          use_cflag = 1'($urandom);
          pend = 1'b1;
        end
        in_valid = pend;
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (out_valid && !out_ready) chk("rand_bp_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("rand_unexpected_valid", 32'(out_valid), 32'd0);
          else chk($sformatf("rand_result%0d", cyc), 32'(outs()), 32'(q.pop_front()));
        end
        if (in_valid && in_ready) begin
          res_t e;
          e = model(s, a, w, use_cflag ? model_c : cin);
          q.push_back(e);
          model_c = e.c;
          pend = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 40 && q.size() > 0; n++) begin
        #1;
        if (out_valid) chk("drain_result", 32'(outs()), 32'(q.pop_front()));
        @(negedge clk);
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
